// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions.
// This package holds the default pixel width and the packed-window width.
// It also holds the lane order of a 2x2 window. The max-pool stage uses
// the same lane order, so both blocks must agree on it.
package cnn_pkg;

  localparam int DATA_W_DEFAULT = 20;
  localparam int WIN_W          = 4 * DATA_W_DEFAULT;

  // Lane order inside a packed window {d,c,b,a}. Lane A is in the lowest bits.
  typedef enum int unsigned {
    LANE_A = 0,  // top-left
    LANE_B = 1,  // top-right
    LANE_C = 2,  // bottom-left
    LANE_D = 3   // bottom-right
  } lane_e;

  localparam int LANE_A_OFF = 0 * DATA_W_DEFAULT;
  localparam int LANE_B_OFF = 1 * DATA_W_DEFAULT;
  localparam int LANE_C_OFF = 2 * DATA_W_DEFAULT;
  localparam int LANE_D_OFF = 3 * DATA_W_DEFAULT;

  // LSB position of a lane, for any pixel width.
  function automatic int lane_lsb(lane_e lane, int data_w);
    return int'(lane) * data_w;
  endfunction

  // Counter/address width for a range 0..n-1. The result is never zero.
  function automatic int cnt_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_window_gen_if.sv
// Streaming handshake bundle around pool_window_gen.
//   in_valid/in_ready/in_pixel      : raster pixel stream into the window builder
//   out_valid/out_ready/out_window  : packed 2x2 windows {d,c,b,a} toward the pool stage
//   frame_done                      : one-cycle end-of-frame pulse
// The master modport is the producer/consumer side. The slave modport is the window builder.
interface pool_window_gen_if
  import cnn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_pixel;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DATA_W-1:0]   out_window;
  logic                  frame_done;

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_window, frame_done
  );

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_window, frame_done
  );

endinterface

// File: rtl/pool_line_buf.sv
// One-row line buffer for the window builder.
// Each entry holds one pixel of the previous even row. Writes are synchronous.
// There are two combinational read ports, so the top-left and top-right
// pixels are both available in the same cycle.
//   clk        : clock
//   we_i       : write enable
//   waddr_i    : write column
//   wdata_i    : write pixel
//   raddr_a_i  : read column, port A (top-left)
//   rdata_a_o  : read data, port A
//   raddr_b_i  : read column, port B (top-right)
//   rdata_b_o  : read data, port B
module pool_line_buf
  import cnn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 26,
  parameter int ADDR_W = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: the storage array has no reset. Every entry is written in an even
  // row before it is read in the next odd row, so the reset value would never be seen.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/pool_window_gen.sv
// Streaming 2x2/stride-2 window builder that feeds the max-pool stage.
// It takes raster-order pixels and emits one packed window {d,c,b,a} per
// non-overlapping 2x2 block. An odd trailing column or row is accepted and dropped.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (aborts the frame and drops any pending window)
//   bus  : slave side of pool_window_gen_if (in/out handshakes, frame_done)
module pool_window_gen
  import cnn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int IMG_W  = 26,
  parameter int IMG_H  = 26
) (
  input  logic               clk,
  input  logic               rst,
  pool_window_gen_if.slave   bus
);

  localparam int COL_W = cnt_w(IMG_W);
  localparam int ROW_W = cnt_w(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [DATA_W-1:0]   held_q, held_d;
  logic [4*DATA_W-1:0] win_q, win_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;

  logic                in_ready;
  logic                accept;
  logic                lb_we;
  logic [COL_W-1:0]    lb_addr_a;
  logic [DATA_W-1:0]   lb_rd_a, lb_rd_b;

  // The output register holds one entry. Input is accepted when that entry is
  // free, or when it is being drained in this same cycle.
  assign in_ready = !valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign lb_we    = accept && !row_q[0];
  // Forming a window needs col-1, and that only happens when col is odd.
  // Clearing the LSB gives col-1 without underflow, so the address stays in range.
  assign lb_addr_a = col_q & ~COL_W'(1);

  pool_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W),
    .ADDR_W (COL_W)
  ) u_line_buf (
    .clk       (clk),
    .we_i      (lb_we),
    .waddr_i   (col_q),
    .wdata_i   (bus.in_pixel),
    .raddr_a_i (lb_addr_a),
    .rdata_a_o (lb_rd_a),
    .raddr_b_i (col_q),
    .rdata_b_o (lb_rd_b)
  );

  // NOTE: every variable is given its hold value first. Each path is then
  // fully assigned, so no latch is inferred.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    held_d  = held_q;
    win_d   = win_q;
    valid_d = valid_q;
    done_d  = 1'b0;

    if (bus.out_ready) valid_d = 1'b0;

    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      done_d = (col_q == COL_LAST) && (row_q == ROW_LAST);

      // An odd trailing column or row is always at an even index, so it never forms a window.
      if (row_q[0] && !col_q[0]) held_d = bus.in_pixel;
      if (row_q[0] && col_q[0]) begin
        win_d[lane_lsb(LANE_A, DATA_W) +: DATA_W] = lb_rd_a;
        win_d[lane_lsb(LANE_B, DATA_W) +: DATA_W] = lb_rd_b;
        win_d[lane_lsb(LANE_C, DATA_W) +: DATA_W] = held_q;
        win_d[lane_lsb(LANE_D, DATA_W) +: DATA_W] = bus.in_pixel;
        valid_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only. All of them then
  // update together at the edge, whatever order the processes are evaluated in.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      held_q  <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      held_q  <= held_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = valid_q;
  assign bus.out_window = win_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_pool_window_gen.sv
// Directed bench for pool_window_gen.
// It uses a 4x4 instance for the main scenarios and a 5x5 instance for odd-size cropping.
module tb_pool_window_gen;
  import cnn_pkg::*;

  localparam int DW = 20;
  localparam int WW = 4 * DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pool_window_gen_if #(.DATA_W(DW)) bus4 ();
  pool_window_gen_if #(.DATA_W(DW)) bus5 ();

  pool_window_gen #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  pool_window_gen #(.DATA_W(DW), .IMG_W(5), .IMG_H(5)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] win(input int a, input int b, input int c, input int d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  // The four 4x4 windows, as listed for raster-index pixels, plus a per-frame offset.
  function automatic logic [WW-1:0] exp4(input int i, input int off);
    case (i)
      0:       return win(0 + off, 1 + off, 4 + off, 5 + off);
      1:       return win(2 + off, 3 + off, 6 + off, 7 + off);
      2:       return win(8 + off, 9 + off, 12 + off, 13 + off);
      default: return win(10 + off, 11 + off, 14 + off, 15 + off);
    endcase
  endfunction

  // Window transfers and frame_done pulses, sampled on the falling edge.
  logic [WW-1:0] q4[$];
  logic [WW-1:0] q5[$];
  int fd4 = 0;
  always @(negedge clk) begin
    if (!rst && bus4.out_valid && bus4.out_ready) q4.push_back(bus4.out_window);
    if (!rst && bus5.out_valid && bus5.out_ready) q5.push_back(bus5.out_window);
    if (bus4.frame_done) fd4++;
  end

  function automatic logic [WW-1:0] q4_at(input int i);
    return (i < q4.size()) ? q4[i] : '0;
  endfunction

  function automatic logic [WW-1:0] q5_at(input int i);
    return (i < q5.size()) ? q5[i] : '0;
  endfunction

  // The task is called at posedge+1. It returns at posedge+1, just after the accepting edge.
  task automatic send4(input logic [DW-1:0] v, input int gap);
    int t;
    repeat (gap) begin @(posedge clk); #1; end
    bus4.in_pixel = v;
    bus4.in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus4.in_ready && t < 200) begin t++; @(negedge clk); end
    if (t >= 200) check("accept4_timeout", 0, 1);
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
  endtask

  task automatic send5(input logic [DW-1:0] v);
    int t;
    bus5.in_pixel = v;
    bus5.in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus5.in_ready && t < 200) begin t++; @(negedge clk); end
    if (t >= 200) check("accept5_timeout", 0, 1);
    @(posedge clk); #1;
    bus5.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus4.in_valid = 1'b0; bus4.in_pixel = '0; bus4.out_ready = 1'b1;
    bus5.in_valid = 1'b0; bus5.in_pixel = '0; bus5.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_out_valid", bus4.out_valid, 0);
    check("rst_out_window", bus4.out_window, 0);
    check("rst_frame_done", bus4.frame_done, 0);
    check("rst_in_ready", bus4.in_ready, 1);

    // Full stream 0..15 with out_ready high. Per-pixel latency and frame_done checks.
    q4.delete();
    for (int k = 0; k < 16; k++) begin
      send4(DW'(k), 0);
      check($sformatf("stream_valid_px%0d", k), bus4.out_valid,
            (k == 5 || k == 7 || k == 13 || k == 15) ? 1 : 0);
      check($sformatf("stream_done_px%0d", k), bus4.frame_done, (k == 15) ? 1 : 0);
      if (k == 5)  check("stream_win_px5",  bus4.out_window, exp4(0, 0));
      if (k == 15) check("stream_win_px15", bus4.out_window, exp4(3, 0));
    end
    idle(2);
    check("stream_count", q4.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("stream_win%0d", i), q4_at(i), exp4(i, 0));

    // Backpressure while the first window is pending
    q4.delete();
    bus4.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) send4(DW'(k), 0);
    bus4.in_pixel = DW'(6);
    bus4.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_in_ready_c%0d", c), bus4.in_ready, 0);
      check($sformatf("bp_valid_c%0d", c), bus4.out_valid, 1);
      check($sformatf("bp_win_c%0d", c), bus4.out_window, exp4(0, 0));
    end
    bus4.out_ready = 1'b1;
    for (int k = 6; k < 16; k++) send4(DW'(k), 0);
    idle(2);
    check("bp_count", q4.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("bp_win%0d", i), q4_at(i), exp4(i, 0));

    // Reset mid-frame with a pending window, then a new frame 100..115
    for (int k = 0; k < 7; k++) send4(DW'(k), 0);
    bus4.out_ready = 1'b0;
    send4(DW'(7), 0);
    check("abort_pending_valid", bus4.out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_out_valid", bus4.out_valid, 0);
    check("abort_out_window", bus4.out_window, 0);
    bus4.out_ready = 1'b1;
    idle(1);
    q4.delete();
    for (int k = 100; k < 116; k++) begin
      send4(DW'(k), 0);
      if (k == 105) check("abort_first_win", bus4.out_window, exp4(0, 100));
      if (k == 115) check("abort_done", bus4.frame_done, 1);
    end
    idle(2);
    check("abort_count", q4.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("abort_win%0d", i), q4_at(i), exp4(i, 100));

    // Two back-to-back frames with random input gaps
    q4.delete();
    fd4 = 0;
    for (int k = 0; k < 32; k++) send4(DW'(k), int'($urandom_range(0, 2)));
    idle(2);
    check("b2b_count", q4.size(), 8);
    check("b2b_frame_done", fd4, 2);
    for (int i = 0; i < 8; i++)
      check($sformatf("b2b_win%0d", i), q4_at(i), exp4(i % 4, 16 * (i / 4)));

    // Full-scale pixel values in every lane
    q4.delete();
    for (int k = 0; k < 16; k++) send4(20'hFFFFF, 0);
    idle(2);
    check("max_count", q4.size(), 4);
    check("max_win0", q4_at(0), 80'hFFFFF_FFFFF_FFFFF_FFFFF);
    check("max_win3", q4_at(3), 80'hFFFFF_FFFFF_FFFFF_FFFFF);

    // 5x5 frame: the last column and last row are dropped
    q5.delete();
    for (int k = 0; k < 25; k++) begin
      send5(DW'(k));
      if (k == 23) check("odd_done_px23", bus5.frame_done, 0);
      if (k == 24) check("odd_done_px24", bus5.frame_done, 1);
    end
    idle(2);
    check("odd_count", q5.size(), 4);
    check("odd_win0", q5_at(0), win(0, 1, 5, 6));
    check("odd_win1", q5_at(1), win(2, 3, 7, 8));
    check("odd_win2", q5_at(2), win(10, 11, 15, 16));
    check("odd_win3", q5_at(3), win(12, 13, 17, 18));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
